// File: rtl/color_tracker_pkg.sv
// Shared constants for the colour tracker: YUV coefficients, pipeline latency,
// FSM state encoding and a small chroma-distance helper.
package tracker_pkg;

  localparam int COEF_YR = 77;
  localparam int COEF_YG = 150;
  localparam int COEF_YB = 37;
  localparam int COEF_U  = 126;
  localparam int COEF_V  = 225;

  // Also consumed by the overlay stage to align its own delay line.
  localparam int PIPE_LAT = 4;
  localparam int PIX_CW   = 13;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN,
    ST_DIV_X,
    ST_DIV_Y,
    ST_DONE
  } state_e;

  // |a-b| for two 9b signed values, evaluated at 10b so it never wraps.
  function automatic logic [9:0] abs_diff9(input logic [8:0] a, input logic [8:0] b);
    logic [9:0] d;
    d = {a[8], a} - {b[8], b};
    return d[9] ? (~d + 10'd1) : d;
  endfunction

endpackage

// File: rtl/color_tracker_seq_divider.sv
// Restoring unsigned divider: one quotient bit per cycle, DVD_W cycles per divide,
// single-cycle done pulse; only the low QUO_W quotient bits are exported.
module seq_divider #(
  parameter int DVD_W = 32,
  parameter int DVS_W = 20,
  parameter int QUO_W = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [QUO_W-1:0] quotient_o
);

  localparam int CW = $clog2(DVD_W + 1);

  logic [DVS_W-1:0] rem_q, dvs_q;
  logic [DVD_W-1:0] quo_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q, done_q;
  logic [DVS_W:0]   rem_sh, trial;

  // Remainder stays below the divisor, so DVS_W+1 bits hold the shifted value.
  assign rem_sh = {rem_q, quo_q[DVD_W-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= '0;
        quo_q  <= dividend_i;
        dvs_q  <= divisor_i;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        if (trial[DVS_W]) begin
          rem_q <= rem_sh[DVS_W-1:0];
          quo_q <= {quo_q[DVD_W-2:0], 1'b0};
        end else begin
          rem_q <= trial[DVS_W-1:0];
          quo_q <= {quo_q[DVD_W-2:0], 1'b1};
        end
        cnt_q <= cnt_q + CW'(1);
        if (cnt_q == CW'(DVD_W - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o     = done_q;
  assign quotient_o = quo_q[QUO_W-1:0];

endmodule

// File: rtl/color_tracker.sv
// Colour tracker: RGB->YUV match pipeline, per-frame hit accumulation and centroid.
// Optional bounding-box outputs when COLOR_TRACKER_BBOX_EN is defined.
module color_tracker import tracker_pkg::*; #(
  parameter int COORD_W  = 10,
  parameter int SUM_W    = 32,
  parameter int CNT_W    = 20,
  parameter int MIN_HITS = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          raw_R,
  input  logic [7:0]          raw_G,
  input  logic [7:0]          raw_B,
  input  logic [PIX_CW-1:0]   row,
  input  logic [PIX_CW-1:0]   col,
  input  logic                pix_valid,
  input  logic                frame_start,
  input  logic                frame_end,
  input  logic [7:0]          ref_Y,
  input  logic signed [8:0]   ref_U,
  input  logic signed [8:0]   ref_V,
  input  logic [7:0]          uv_tol,
  input  logic [7:0]          y_min,
  output logic                mask,
  output logic                mask_valid,
  output logic [PIX_CW-1:0]   mask_row,
  output logic [PIX_CW-1:0]   mask_col,
  output logic [COORD_W-1:0]  cen_row,
  output logic [COORD_W-1:0]  cen_col,
  output logic                found,
  output logic                result_valid
`ifdef COLOR_TRACKER_BBOX_EN
  ,
  output logic [COORD_W-1:0]  bb_rmin,
  output logic [COORD_W-1:0]  bb_rmax,
  output logic [COORD_W-1:0]  bb_cmin,
  output logic [COORD_W-1:0]  bb_cmax
`endif
);

  // Reference luma belongs to the calibration interface; matching uses chroma + y_min.
  logic unused_ref_y;
  assign unused_ref_y = ^ref_Y;

  logic [PIPE_LAT:1]                  vld_pipe_q;
  logic [PIPE_LAT-1:0][PIX_CW-1:0]    row_pipe_q, col_pipe_q;
  logic [14:0]                        pr_q;
  logic [15:0]                        pg_q;
  logic [13:0]                        pb_q;
  logic [7:0]                         r1_q, b1_q, y2_q, y3_q, y_s2;
  logic signed [8:0]                  db2_q, dr2_q, u3_q, v3_q;
  logic                               mask_q, s4_hit;

  assign y_s2   = 8'((17'(pr_q) + 17'(pg_q) + 17'(pb_q)) >> 8);
  assign s4_hit = vld_pipe_q[PIPE_LAT-1] && (y3_q >= y_min)
                  && (abs_diff9(u3_q, ref_U) <= {2'b00, uv_tol})
                  && (abs_diff9(v3_q, ref_V) <= {2'b00, uv_tol});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld_pipe_q <= '0;
      row_pipe_q <= '0;
      col_pipe_q <= '0;
      pr_q <= '0; pg_q <= '0; pb_q <= '0;
      r1_q <= '0; b1_q <= '0;
      y2_q <= '0; y3_q <= '0;
      db2_q <= '0; dr2_q <= '0;
      u3_q <= '0; v3_q <= '0;
      mask_q <= 1'b0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[PIPE_LAT-1:1], pix_valid};
      row_pipe_q <= {row_pipe_q[PIPE_LAT-2:0], row};
      col_pipe_q <= {col_pipe_q[PIPE_LAT-2:0], col};
      pr_q  <= 15'(raw_R) * 15'(COEF_YR);
      pg_q  <= 16'(raw_G) * 16'(COEF_YG);
      pb_q  <= 14'(raw_B) * 14'(COEF_YB);
      r1_q  <= raw_R;
      b1_q  <= raw_B;
      y2_q  <= y_s2;
      db2_q <= $signed({1'b0, b1_q}) - $signed({1'b0, y_s2});
      dr2_q <= $signed({1'b0, r1_q}) - $signed({1'b0, y_s2});
      y3_q  <= y2_q;
      u3_q  <= 9'((18'(db2_q) * 18'(COEF_U)) >>> 8);
      v3_q  <= 9'((18'(dr2_q) * 18'(COEF_V)) >>> 8);
      mask_q <= s4_hit;
    end
  end

  // Frame accumulation and centroid FSM.
  state_e               state_q, state_d;
  logic [1:0]           drain_q, drain_d;
  logic                 hit_ok_q, hit_ok_d;
  logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [SUM_W-1:0]     sum_r_q, sum_r_d, sum_c_q, sum_c_d;
  logic [COORD_W-1:0]   cen_row_q, cen_col_q;
  logic                 found_q, result_valid_q;
  logic                 div_start, div_done;
  logic [SUM_W-1:0]     div_dvd;
  logic [COORD_W-1:0]   div_quo;
  logic                 acc_hit, acc_clr;
  logic [COORD_W-1:0]   hit_r, hit_c;
  logic [CNT_W:0]       cnt_inc;
  logic [SUM_W:0]       sr_inc, sc_inc;

  assign hit_r   = row_pipe_q[PIPE_LAT-1][COORD_W-1:0];
  assign hit_c   = col_pipe_q[PIPE_LAT-1][COORD_W-1:0];
  assign acc_hit = (state_q == ST_ACCUM || state_q == ST_DRAIN) && mask_q && vld_pipe_q[PIPE_LAT];
  assign acc_clr = (state_d == ST_ACCUM) && (state_q != ST_ACCUM);
  assign cnt_inc = {1'b0, count_q} + (CNT_W+1)'(1);
  assign sr_inc  = {1'b0, sum_r_q} + (SUM_W+1)'(hit_r);
  assign sc_inc  = {1'b0, sum_c_q} + (SUM_W+1)'(hit_c);

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    hit_ok_d  = hit_ok_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    div_start = 1'b0;
    div_dvd   = sum_c_q;
    case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_ACCUM;
      ST_ACCUM: if (frame_end) begin
        state_d = ST_DRAIN;
        drain_d = '0;
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'(PIPE_LAT - 1)) begin
          if (count_q >= CNT_W'(MIN_HITS)) begin
            state_d   = ST_DIV_X;
            hit_ok_d  = 1'b1;
            div_start = 1'b1;
          end else begin
            state_d  = ST_DONE;
            hit_ok_d = 1'b0;
          end
        end
      end
      ST_DIV_X: if (div_done) begin
        cx_d      = div_quo;
        div_start = 1'b1;
        div_dvd   = sum_r_q;
        state_d   = ST_DIV_Y;
      end
      ST_DIV_Y: if (div_done) begin
        cy_d    = div_quo;
        state_d = ST_DONE;
      end
      ST_DONE:  state_d = frame_start ? ST_ACCUM : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    sum_r_d = sum_r_q;
    sum_c_d = sum_c_q;
    if (acc_clr) begin
      count_d = '0;
      sum_r_d = '0;
      sum_c_d = '0;
    end else if (acc_hit) begin
      count_d = cnt_inc[CNT_W] ? '1 : cnt_inc[CNT_W-1:0];
      sum_r_d = sr_inc[SUM_W]  ? '1 : sr_inc[SUM_W-1:0];
      sum_c_d = sc_inc[SUM_W]  ? '1 : sc_inc[SUM_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      drain_q        <= '0;
      hit_ok_q       <= 1'b0;
      cx_q           <= '0;
      cy_q           <= '0;
      count_q        <= '0;
      sum_r_q        <= '0;
      sum_c_q        <= '0;
      cen_row_q      <= '0;
      cen_col_q      <= '0;
      found_q        <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      drain_q        <= drain_d;
      hit_ok_q       <= hit_ok_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      count_q        <= count_d;
      sum_r_q        <= sum_r_d;
      sum_c_q        <= sum_c_d;
      result_valid_q <= (state_q == ST_DONE);
      if (state_q == ST_DONE) begin
        found_q <= hit_ok_q;
        if (hit_ok_q) begin
          cen_row_q <= cy_q;
          cen_col_q <= cx_q;
        end
      end
    end
  end

  seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W), .QUO_W(COORD_W)) u_div (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (div_start),
    .dividend_i (div_dvd),
    .divisor_i  (count_q),
    .done_o     (div_done),
    .quotient_o (div_quo)
  );

`ifdef COLOR_TRACKER_BBOX_EN
  logic [COORD_W-1:0] rmin_q, rmax_q, cmin_q, cmax_q;
  logic [COORD_W-1:0] bb_rmin_q, bb_rmax_q, bb_cmin_q, bb_cmax_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rmin_q <= '0; rmax_q <= '0; cmin_q <= '0; cmax_q <= '0;
      bb_rmin_q <= '0; bb_rmax_q <= '0; bb_cmin_q <= '0; bb_cmax_q <= '0;
    end else begin
      if (acc_clr) begin
        rmin_q <= '1; rmax_q <= '0;
        cmin_q <= '1; cmax_q <= '0;
      end else if (acc_hit) begin
        if (hit_r < rmin_q) rmin_q <= hit_r;
        if (hit_r > rmax_q) rmax_q <= hit_r;
        if (hit_c < cmin_q) cmin_q <= hit_c;
        if (hit_c > cmax_q) cmax_q <= hit_c;
      end
      if (state_q == ST_DONE && hit_ok_q) begin
        bb_rmin_q <= rmin_q; bb_rmax_q <= rmax_q;
        bb_cmin_q <= cmin_q; bb_cmax_q <= cmax_q;
      end
    end
  end

  assign bb_rmin = bb_rmin_q;
  assign bb_rmax = bb_rmax_q;
  assign bb_cmin = bb_cmin_q;
  assign bb_cmax = bb_cmax_q;
`endif

  assign mask         = mask_q;
  assign mask_valid   = vld_pipe_q[PIPE_LAT];
  assign mask_row     = row_pipe_q[PIPE_LAT-1];
  assign mask_col     = col_pipe_q[PIPE_LAT-1];
  assign cen_row      = cen_row_q;
  assign cen_col      = cen_col_q;
  assign found        = found_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_color_tracker.sv
// Scoreboard bench for color_tracker: directed pixels and frames push expected
// mask/result entries; a negedge monitor pops and compares on mask_valid/result_valid.
module tb_color_tracker;

  logic clk, reset_n;
  logic [7:0] raw_R, raw_G, raw_B;
  logic [12:0] row, col;
  logic pix_valid, frame_start, frame_end;
  logic [7:0] ref_Y, uv_tol, y_min;
  logic signed [8:0] ref_U, ref_V;
  logic mask, mask_valid, found, result_valid;
  logic [12:0] mask_row, mask_col;
  logic [9:0] cen_row, cen_col;
`ifdef COLOR_TRACKER_BBOX_EN
  logic [9:0] bb_rmin, bb_rmax, bb_cmin, bb_cmax;
`endif

  color_tracker dut (
    .clk(clk), .reset_n(reset_n),
    .raw_R(raw_R), .raw_G(raw_G), .raw_B(raw_B),
    .row(row), .col(col), .pix_valid(pix_valid),
    .frame_start(frame_start), .frame_end(frame_end),
    .ref_Y(ref_Y), .ref_U(ref_U), .ref_V(ref_V),
    .uv_tol(uv_tol), .y_min(y_min),
    .mask(mask), .mask_valid(mask_valid),
    .mask_row(mask_row), .mask_col(mask_col),
    .cen_row(cen_row), .cen_col(cen_col),
    .found(found), .result_valid(result_valid)
`ifdef COLOR_TRACKER_BBOX_EN
    , .bb_rmin(bb_rmin), .bb_rmax(bb_rmax), .bb_cmin(bb_cmin), .bb_cmax(bb_cmax)
`endif
  );

  typedef struct { logic m; logic [12:0] r; logic [12:0] c; int cyc; } mexp_t;
  typedef struct { logic f; int cr; int cc; int rmin; int rmax; int cmin; int cmax; } rexp_t;

  mexp_t mq[$];
  rexp_t rq[$];
  mexp_t me;
  rexp_t re;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus, compares whenever the DUT presents output.
  always @(negedge clk) begin
    if (mask_valid === 1'b1) begin
      if (mq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mask_unexpected: got row %0d col %0d expected no output", mask_row, mask_col);
      end else begin
        me = mq.pop_front();
        chk("mask", 32'(mask), 32'(me.m));
        chk("mask_row", 32'(mask_row), 32'(me.r));
        chk("mask_col", 32'(mask_col), 32'(me.c));
        chk("mask_latency_cycle", 32'(cyc), 32'(me.cyc));
      end
    end
    if (result_valid === 1'b1) begin
      if (rq.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL result_unexpected: got result_valid=1 expected 0");
      end else begin
        re = rq.pop_front();
        chk("found", 32'(found), 32'(re.f));
        chk("cen_row", 32'(cen_row), 32'(re.cr));
        chk("cen_col", 32'(cen_col), 32'(re.cc));
`ifdef COLOR_TRACKER_BBOX_EN
        chk("bb_rmin", 32'(bb_rmin), 32'(re.rmin));
        chk("bb_rmax", 32'(bb_rmax), 32'(re.rmax));
        chk("bb_cmin", 32'(bb_cmin), 32'(re.cmin));
        chk("bb_cmax", 32'(bb_cmax), 32'(re.cmax));
`endif
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      pix_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    end
  endtask

  task automatic px(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                    input int rw, input int cl, input logic em);
    @(posedge clk); #1;
    raw_R = r; raw_G = g; raw_B = b;
    row = 13'(rw); col = 13'(cl);
    pix_valid = 1'b1; frame_start = 1'b0; frame_end = 1'b0;
    mq.push_back('{m: em, r: 13'(rw), c: 13'(cl), cyc: cyc + 4});
  endtask

  // Hit colour (200,40,40): Y=89 U=-25 V=97. Miss colour (40,200,40): Y=135 U=-47 V=-84.
  task automatic hit(input int rw, input int cl);
    px(8'd200, 8'd40, 8'd40, rw, cl, 1'b1);
  endtask
  task automatic miss(input int rw, input int cl);
    px(8'd40, 8'd200, 8'd40, rw, cl, 1'b0);
  endtask

  task automatic fs();
    @(posedge clk); #1;
    pix_valid = 1'b0; frame_end = 1'b0; frame_start = 1'b1;
  endtask
  task automatic fe();
    @(posedge clk); #1;
    pix_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b1;
    idle(1);
  endtask

  task automatic block_frame();
    fs();
    for (int r = 100; r < 110; r++)
      for (int c = 198; c < 212; c++)
        if (c >= 200 && c <= 209) hit(r, c); else miss(r, c);
    fe();
  endtask

  task automatic wait_res(input int budget);
    int n;
    n = 0;
    while (rq.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (rq.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL result_timeout: got %0d pending results expected 0 after %0d cycles", rq.size(), budget);
      rq.delete();
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, "_mask"}, 32'(mask), 32'd0);
    chk({t, "_mask_valid"}, 32'(mask_valid), 32'd0);
    chk({t, "_mask_row"}, 32'(mask_row), 32'd0);
    chk({t, "_mask_col"}, 32'(mask_col), 32'd0);
    chk({t, "_cen_row"}, 32'(cen_row), 32'd0);
    chk({t, "_cen_col"}, 32'(cen_col), 32'd0);
    chk({t, "_found"}, 32'(found), 32'd0);
    chk({t, "_result_valid"}, 32'(result_valid), 32'd0);
`ifdef COLOR_TRACKER_BBOX_EN
    chk({t, "_bb_rmin"}, 32'(bb_rmin), 32'd0);
    chk({t, "_bb_cmax"}, 32'(bb_cmax), 32'd0);
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    raw_R = '0; raw_G = '0; raw_B = '0; row = '0; col = '0;
    pix_valid = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    ref_Y = 8'd89; ref_U = -9'sd25; ref_V = 9'sd97; uv_tol = 8'd8; y_min = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset_n = 1'b1;
    idle(2);

    // Single pixels: match, colour miss, y_min and tolerance boundaries.
    hit(5, 7);                               idle(6);
    miss(6, 8);                              idle(6);
    y_min = 8'd90; px(8'd200, 8'd40, 8'd40, 7, 9, 1'b0);  idle(6);
    y_min = 8'd89; px(8'd200, 8'd40, 8'd40, 8, 10, 1'b1); idle(6);
    y_min = 8'd0;
    ref_U = -9'sd17; px(8'd200, 8'd40, 8'd40, 9, 11, 1'b1);  idle(6);
    ref_U = -9'sd16; px(8'd200, 8'd40, 8'd40, 10, 12, 1'b0); idle(6);
    ref_U = -9'sd33; px(8'd200, 8'd40, 8'd40, 11, 13, 1'b1); idle(6);
    ref_U = -9'sd25;
    ref_V = 9'sd106; px(8'd200, 8'd40, 8'd40, 12, 14, 1'b0); idle(6);
    ref_V = 9'sd97;

    // 10x10 block: count 100, sum_r 10450, sum_c 20450.
    rq.push_back('{f: 1'b1, cr: 104, cc: 204, rmin: 100, rmax: 109, cmin: 200, cmax: 209});
    block_frame();
    wait_res(200);

    // Too few hits: found drops, centroid and box hold.
    rq.push_back('{f: 1'b0, cr: 104, cc: 204, rmin: 100, rmax: 109, cmin: 200, cmax: 209});
    fs();
    for (int i = 0; i < 5; i++) hit(50, 10 + i);
    fe();
    wait_res(200);

    // 13 + 3 hits; the last three land right before frame_end. sum_r 323, sum_c 81.
    rq.push_back('{f: 1'b1, cr: 20, cc: 5, rmin: 20, rmax: 21, cmin: 0, cmax: 12});
    fs();
    for (int i = 0; i < 13; i++) hit(20, i);
    for (int i = 0; i < 3; i++) hit(21, i);
    fe();
    // A new frame launched while dividing is skipped entirely.
    idle(15);
    fs();
    for (int i = 0; i < 16; i++) hit(300, i);
    fe();
    wait_res(200);
    idle(100);

    // Reset while dividing: outputs clear and no result appears.
    block_frame();
    idle(45);
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk_zero("reset_div");
    reset_n = 1'b1;
    idle(120);

    // Recovery after the abort.
    rq.push_back('{f: 1'b1, cr: 104, cc: 204, rmin: 100, rmax: 109, cmin: 200, cmax: 209});
    block_frame();
    wait_res(200);

    idle(10);
    chk("mask_queue_drained", 32'(mq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
